// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl -- single-outstanding load/store unit controller
//
// Accepts one load or store request, performs a single-cycle access on a
// word-addressed memory with byte-lane enables, and returns a one-cycle
// response pulse carrying extended load data.
//
//   FSM: IDLE -> ACCESS -> RESP -> IDLE
//   Latency: accept on edge N, memory access in cycle N+1, resp_valid in
//   cycle N+2.  Throughput is one request every 3 cycles.
//
// Handshake: a request transfers on a rising edge where req_valid=1 and
// req_ready=1.  req_ready is high only in IDLE.  resp_valid is a
// single-cycle pulse with no back-pressure.  flush (and reset above it)
// wins over a simultaneous req_valid.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   req_valid/req_ready     request handshake
//   req_we                  1 = store, 0 = load
//   req_funct3              RISC-V style size/sign (LB/LH/LW/LBU/LHU)
//   req_addr, req_wdata     byte address, LSB-aligned store data
//   flush                   abort any in-flight request
//   resp_valid              one-cycle completion pulse
//   resp_rdata              extended load data (0 for stores), held
//   resp_misalign           misaligned-access flag (trap build only)
//   mem_addrL, mem_addrS    word index for load / store
//   mem_store, mem_mask     lane-aligned store data and byte enables
//   mem_cs, mem_wr          active-low chip select, write enable
//   mem_rdata               combinational read data from memory
//   dbg_state               current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
//
// Build option
//   LSU_MISALIGN_TRAP_EN    when defined, misaligned halfword/word accesses
//                           skip the memory and respond with
//                           resp_misalign=1, resp_rdata=0.  When undefined,
//                           the low address bits outside the access size
//                           are ignored and resp_misalign is tied to 0.
// ---------------------------------------------------------------------------
module lsu_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misalign,
  output logic [31:0] mem_addrL,
  output logic [31:0] mem_addrS,
  output logic [31:0] mem_store,
  output logic [3:0]  mem_mask,
  output logic        mem_cs,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  // Access decode from the registered request
  logic        size_byte;
  logic        size_half;
  logic        size_word;
  logic        zero_ext;
  logic [1:0]  offset;
  logic        misalign;
  logic [3:0]  store_mask;
  logic [31:0] store_data;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_ext;
  logic [31:0] capture_data;

  logic        accept;
  logic        capture;

  // ---------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------
  // funct3[1:0]: 00 byte, 01 half, 1x word.  Reserved encodings 011, 110
  // and 111 all land in the 1x bucket and therefore behave as LW/SW.
  assign size_byte = (funct3_q[1:0] == 2'b00);
  assign size_half = (funct3_q[1:0] == 2'b01);
  assign size_word = funct3_q[1];
  assign zero_ext  = funct3_q[2];
  assign offset    = addr_q[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (size_half && offset[0]) ||
                    (size_word && (offset != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Halfword lanes use only addr[1]; a halfword at offset 3 would shift
  // the mask off the top of the word, so it is pinned to the aligned pair.
  always_comb begin
    store_mask = 4'b1111;
    store_data = wdata_q;
    if (size_byte) begin
      store_mask = 4'b0001 << offset;
      store_data = {4{wdata_q[7:0]}};
    end else if (size_half) begin
      store_mask = offset[1] ? 4'b1100 : 4'b0011;
      store_data = {2{wdata_q[15:0]}};
    end
  end

  // Load lane select and extension
  always_comb begin
    load_byte = mem_rdata[7:0];
    case (offset)
      2'd0:    load_byte = mem_rdata[7:0];
      2'd1:    load_byte = mem_rdata[15:8];
      2'd2:    load_byte = mem_rdata[23:16];
      default: load_byte = mem_rdata[31:24];
    endcase
    load_half = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    load_ext = mem_rdata;
    if (size_byte) begin
      load_ext = zero_ext ? {24'd0, load_byte}
                          : {{24{load_byte[7]}}, load_byte};
    end else if (size_half) begin
      load_ext = zero_ext ? {16'd0, load_half}
                          : {{16{load_half[15]}}, load_half};
    end
  end

  // Stores and trapped accesses report zero data
  assign capture_data = (we_q || misalign) ? 32'd0 : load_ext;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  assign accept  = (state_q == ST_IDLE) && req_valid && !flush;
  assign capture = (state_q == ST_ACCESS) && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
      // mem_rdata is sampled on the edge that closes the ACCESS cycle; a
      // flushed access leaves the previous response data in place.
      if (capture) begin
        rdata_q <= capture_data;
      end
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else if (capture) begin
      misalign_q <= misalign;
    end
  end

  assign resp_misalign = misalign_q && (state_q == ST_RESP);
`else
  assign resp_misalign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!flush && req_valid) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_d = flush ? ST_IDLE : ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Outputs: decoded from registered state only, so every memory-side
  // output moves on the rising edge.
  // ---------------------------------------------------------------------
  always_comb begin
    req_ready  = (state_q == ST_IDLE);
    resp_valid = (state_q == ST_RESP);
    mem_cs     = 1'b1;
    mem_wr     = 1'b0;
    mem_mask   = 4'b0000;
    mem_store  = 32'd0;
    if ((state_q == ST_ACCESS) && !misalign) begin
      mem_cs = 1'b0;
      mem_wr = we_q;
      if (we_q) begin
        mem_mask  = store_mask;
        mem_store = store_data;
      end
    end
  end

  assign resp_rdata = rdata_q;
  assign mem_addrL  = {2'b00, addr_q[31:2]};
  assign mem_addrS  = {2'b00, addr_q[31:2]};
  assign dbg_state  = state_q;

endmodule
